xor_decrypt_receiver: RTL and testbench

- Far end of the ciphertext serial link: consumes the framed stream from the XOR cipher output (serial_out, serial_start, serial_end).
- XORs each received bit on the fly with a repeating 32-bit key; recovered bits are packed into plaintext bytes.
- Bytes leave through a small FIFO with a valid/ready handshake; frame status flags report length and overflow errors.

---
 rtl/xor_cipher_pkg.sv | 22 ++
 rtl/sync_byte_fifo.sv | 60 ++++++
 rtl/xor_decrypt_receiver.sv | 192 +++++++++++++++++++
 tb/tb_xor_decrypt_receiver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// ============================================================================
// Module      : xor_cipher_pkg
// Description : Shared constants and FSM state type for the XOR cipher paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xor_cipher_pkg;

    localparam int KEY_SIZE_DEF = 32;
    localparam int MSG_SIZE_DEF = 512;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_byte_fifo.sv
// ============================================================================
// Module      : sync_byte_fifo
// Description : Synchronous FIFO, power-of-two depth, simultaneous push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign w_pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = push_i && (!full_o || w_pop_ok);
    assign data_o    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop_ok);
        end
    end

endmodule

`default_nettype wire

// File: rtl/xor_decrypt_receiver.sv
// ============================================================================
// Module      : xor_decrypt_receiver
// Description : Serial XOR-decrypting receiver packing plaintext into a byte
//               FIFO. Optional macro XOR_RX_BITCOUNT_EN adds oBit_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_decrypt_receiver
    import xor_cipher_pkg::*;
#(
    parameter int KEY_SIZE   = KEY_SIZE_DEF,
    parameter int MAX_BITS   = MSG_SIZE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iEn,
    input  logic [KEY_SIZE-1:0]       iKey,
    input  logic                      iKey_load,
    input  logic                      iSerial_in,
    input  logic                      iSerial_start,
    input  logic                      iSerial_end,
    output logic [BYTE_W-1:0]         oByte,
    output logic                      oByte_valid,
    input  logic                      iByte_ready,
`ifdef XOR_RX_BITCOUNT_EN
    output logic [$clog2(MAX_BITS):0] oBit_count,
`endif
    output logic                      oFrame_done,
    output logic                      oFrame_err,
    output logic                      oOverflow
);

    localparam int CNT_W  = $clog2(MAX_BITS) + 1;
    localparam int KCNT_W = $clog2(KEY_SIZE);
    localparam int LOG_B  = $clog2(BYTE_W);

    localparam logic [CNT_W-1:0]  C_MAX_BITS = CNT_W'(MAX_BITS);
    localparam logic [KCNT_W-1:0] C_KEY_TOP  = KCNT_W'(KEY_SIZE - 1);

    rx_state_e             state_q, state_d;
    logic [KEY_SIZE-1:0]   key_q, key_d;
    logic [KCNT_W-1:0]     kcnt_q, kcnt_d;
    logic [CNT_W-1:0]      bcnt_q, bcnt_d;
    logic [BYTE_W-2:0]     shift_q, shift_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;

    logic                  w_take;
    logic                  w_restart;
    logic                  w_push;
    logic                  w_dbit;
    logic [CNT_W-1:0]      w_bbase;
    logic [CNT_W-1:0]      w_bnext;
    logic [KCNT_W-1:0]     w_kbase;
    logic [BYTE_W-1:0]     w_push_byte;
    logic                  w_full;
    logic                  w_empty;

    assign w_push_byte = {shift_q, w_dbit};

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        kcnt_d    = kcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        err_d     = err_q;
        ovf_d     = ovf_q;
        w_take    = 1'b0;
        w_restart = 1'b0;
        w_push    = 1'b0;

        case (state_q)
            IDLE: begin
                if (iKey_load) key_d = iKey;
                if (iEn && iSerial_start) begin
                    w_take    = 1'b1;
                    w_restart = 1'b1;
                end
            end
            RECV: begin
                if (iEn) begin
                    w_take    = 1'b1;
                    w_restart = iSerial_start;
                end
            end
            DROP: begin
                if (iEn) begin
                    bcnt_d = (&bcnt_q) ? bcnt_q : bcnt_q + 1'b1;
                    if (iSerial_end) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        w_bbase = w_restart ? '0 : bcnt_q;
        w_kbase = w_restart ? '0 : kcnt_q;
        w_bnext = w_bbase + 1'b1;
        // Key is applied MSB first, so bit n uses key[KEY_SIZE-1-(n mod KEY_SIZE)].
        w_dbit  = iSerial_in ^ key_q[C_KEY_TOP - w_kbase];

        if (w_restart) begin
            err_d = 1'b0;
            ovf_d = 1'b0;
        end

        if (w_take) begin
            if (w_bnext > C_MAX_BITS) begin
                err_d   = 1'b1;
                bcnt_d  = w_bnext;
                state_d = iSerial_end ? IDLE : DROP;
            end else begin
                shift_d = {shift_q[BYTE_W-3:0], w_dbit};
                bcnt_d  = w_bnext;
                kcnt_d  = w_kbase + 1'b1;
                w_push  = (w_bnext[LOG_B-1:0] == '0);
                if (iSerial_end) begin
                    state_d = IDLE;
                    if (w_push) done_d = 1'b1;
                    else        err_d  = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
        end

        if (w_push && w_full && !(iByte_ready && !w_empty)) ovf_d = 1'b1;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            key_q   <= '0;
            kcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            kcnt_q  <= kcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef XOR_RX_BITCOUNT_EN
    logic [CNT_W-1:0] bc_rep_q;

    // Every termination path leaves the frame length in bcnt_d.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            bc_rep_q <= '0;
        end else if (iEn && iSerial_end && (w_take || state_q == DROP)) begin
            bc_rep_q <= bcnt_d;
        end
    end

    assign oBit_count = bc_rep_q;
`endif

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .push_i  (w_push),
        .data_i  (w_push_byte),
        .pop_i   (iByte_ready),
        .data_o  (oByte),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign oByte_valid = !w_empty;
    assign oFrame_done = done_q;
    assign oFrame_err  = err_q;
    assign oOverflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_decrypt_receiver.sv
// ============================================================================
// Module      : tb_xor_decrypt_receiver
// Description : Self-checking bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_decrypt_receiver;

    logic        iClk, iRst, iEn, iKey_load, iSerial_in, iSerial_start, iSerial_end;
    logic        iByte_ready;
    logic [31:0] iKey;
    logic [7:0]  oByte;
    logic        oByte_valid, oFrame_done, oFrame_err, oOverflow;
`ifdef XOR_RX_BITCOUNT_EN
    logic [9:0]  oBit_count;
`endif

    xor_decrypt_receiver dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iEn           (iEn),
        .iKey          (iKey),
        .iKey_load     (iKey_load),
        .iSerial_in    (iSerial_in),
        .iSerial_start (iSerial_start),
        .iSerial_end   (iSerial_end),
        .oByte         (oByte),
        .oByte_valid   (oByte_valid),
        .iByte_ready   (iByte_ready),
`ifdef XOR_RX_BITCOUNT_EN
        .oBit_count    (oBit_count),
`endif
        .oFrame_done   (oFrame_done),
        .oFrame_err    (oFrame_err),
        .oOverflow     (oOverflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_mode = 1;   // 0 = low, 1 = high, 2 = random

    // Reference model: frame mode 0 idle / 1 receiving / 2 dropping.
    int          m_mode = 0;
    int          m_n    = 0;     // bits stored in current frame
    int          m_fb   = 0;     // bits seen in current frame, including dropped
    int          m_bc   = 0;
    logic [7:0]  m_cur  = 8'h00;
    logic [31:0] m_key  = 32'h0;
    bit          m_done = 0, m_err = 0, m_ovf = 0;
    logic [7:0]  mq[$];
    logic [7:0]  got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         take = 0;
        bit         push = 0;
        logic [7:0] pb   = 8'h00;
        int         pm   = m_mode;
        if (iRst) begin
            m_mode = 0; m_n = 0; m_fb = 0; m_bc = 0; m_cur = 8'h00; m_key = 32'h0;
            m_done = 0; m_err = 0; m_ovf = 0;
            mq.delete();
            return;
        end
        m_done = 0;
        if (iEn) begin
            if (iSerial_start && m_mode != 2) begin
                m_mode = 1; m_n = 0; m_fb = 0; m_err = 0; m_ovf = 0;
                take = 1;
            end else if (m_mode == 1) begin
                take = 1;
            end else if (m_mode == 2) begin
                if (m_fb < 1023) m_fb++;
                if (iSerial_end) begin
                    m_mode = 0;
                    m_bc   = m_fb;
                end
            end
            if (take) begin
                m_fb++;
                if (m_n + 1 > 512) begin
                    m_err  = 1;
                    m_mode = iSerial_end ? 0 : 2;
                    if (iSerial_end) m_bc = m_fb;
                end else begin
                    m_cur = {m_cur[6:0], iSerial_in ^ m_key[31 - (m_n % 32)]};
                    m_n++;
                    if (m_n % 8 == 0) begin
                        push = 1;
                        pb   = m_cur;
                    end
                    if (iSerial_end) begin
                        m_mode = 0;
                        m_bc   = m_fb;
                        if (m_n % 8 == 0) m_done = 1;
                        else              m_err  = 1;
                    end
                end
            end
        end
        if (pm == 0 && iKey_load) m_key = iKey;
        if (mq.size() > 0 && iByte_ready) got.push_back(mq.pop_front());
        if (push) begin
            if (mq.size() < 4) mq.push_back(pb);
            else               m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        chk("valid", {31'd0, oByte_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) chk("byte", {24'd0, oByte}, {24'd0, mq[0]});
        chk("done", {31'd0, oFrame_done}, {31'd0, m_done});
        chk("err",  {31'd0, oFrame_err},  {31'd0, m_err});
        chk("ovf",  {31'd0, oOverflow},   {31'd0, m_ovf});
`ifdef XOR_RX_BITCOUNT_EN
        chk("bitcnt", {22'd0, oBit_count}, m_bc);
`endif
    endtask

    task automatic cycle();
        iByte_ready = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
        @(posedge iClk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int k);
        iEn = 0; iSerial_start = 0; iSerial_end = 0; iKey_load = 0;
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic load_key(input logic [31:0] k);
        iEn = 0; iSerial_start = 0; iSerial_end = 0;
        iKey = k; iKey_load = 1;
        cycle();
        iKey_load = 0;
    endtask

    task automatic send_bits(input logic [1023:0] ct, input int len, input bit with_end,
                             input int gap_pct);
        for (int n = 0; n < len; n++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                iEn = 0;
                iSerial_in = 1'($urandom); iSerial_start = 1'($urandom);
                iSerial_end = 1'($urandom);
                cycle();
            end
            iEn = 1;
            iSerial_in    = ct[len-1-n];
            iSerial_start = (n == 0);
            iSerial_end   = with_end && (n == len - 1);
            cycle();
        end
        iEn = 0; iSerial_start = 0; iSerial_end = 0;
    endtask

    task automatic rand_ct(output logic [1023:0] ct);
        for (int w = 0; w < 32; w++) ct[w*32 +: 32] = $urandom;
    endtask

    logic [1023:0] ct;
    logic [7:0]    exp_b[4];

    initial begin
        iRst = 1; iEn = 0; iKey = 32'h0; iKey_load = 0; iSerial_in = 0;
        iSerial_start = 0; iSerial_end = 0; iByte_ready = 0;
        exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h78;
        cycle(); cycle();
        iRst = 0;
        chk("rst_byte",  {24'd0, oByte}, 32'h0);
        chk("rst_valid", {31'd0, oByte_valid}, 32'h0);
        chk("rst_done",  {31'd0, oFrame_done}, 32'h0);
        chk("rst_err",   {31'd0, oFrame_err}, 32'h0);
        chk("rst_ovf",   {31'd0, oOverflow}, 32'h0);

        // All-zero ciphertext reveals the key itself
        rdy_mode = 1;
        load_key(32'hA5A5A5A5);
        got.delete();
        send_bits('0, 32, 1, 0);
        chk("t1_done", {31'd0, oFrame_done}, 32'h1);
        idle(3);
        chk("t1_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk("t1_byte", {24'd0, got[i]}, 32'hA5);
        chk("t1_err", {31'd0, oFrame_err}, 32'h0);
        chk("t1_ovf", {31'd0, oOverflow}, 32'h0);

        // Ciphertext equal to the key across a key wrap
        load_key(32'h12345678);
        got.delete();
        ct = '0; ct[63:0] = 64'h1234567812345678;
        send_bits(ct, 64, 1, 0);
        idle(3);
        chk("t2_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk("t2_byte", {24'd0, got[i]}, 32'h0);

        // Consumer stalled: bytes 5 and 6 overflow
        rdy_mode = 0;
        got.delete();
        send_bits('0, 48, 1, 0);
        idle(2);
        chk("t3_ovf",   {31'd0, oOverflow}, 32'h1);
        chk("t3_valid", {31'd0, oByte_valid}, 32'h1);
        rdy_mode = 1;
        idle(6);
        chk("t3_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("t3_byte", {24'd0, got[i]}, {24'd0, exp_b[i]});

        // 12-bit frame: one byte, then length error
        got.delete();
        send_bits('0, 12, 1, 0);
        chk("t4_done", {31'd0, oFrame_done}, 32'h0);
        idle(3);
        chk("t4_count", got.size(), 1);
        if (got.size() > 0) chk("t4_byte", {24'd0, got[0]}, 32'h12);
        chk("t4_err", {31'd0, oFrame_err}, 32'h1);

        // Oversized frame: 64 bytes kept, rest dropped
        got.delete();
        rand_ct(ct);
        send_bits(ct, 520, 1, 0);
        idle(3);
        chk("t5_count", got.size(), 64);
        if (got.size() > 0) chk("t5_first", {24'd0, got[0]}, {24'd0, ct[519:512] ^ 8'h12});
        chk("t5_err", {31'd0, oFrame_err}, 32'h1);

        // Restart after 5 bits
        got.delete();
        rand_ct(ct);
        send_bits(ct, 5, 0, 0);
        send_bits('0, 32, 1, 0);
        idle(3);
        chk("t6_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("t6_byte", {24'd0, got[i]}, {24'd0, exp_b[i]});
        chk("t6_err", {31'd0, oFrame_err}, 32'h0);

        // Reset in the middle of a frame with bytes queued
        rdy_mode = 0;
        send_bits('0, 48, 0, 0);
        chk("t7_pre_valid", {31'd0, oByte_valid}, 32'h1);
        chk("t7_pre_ovf",   {31'd0, oOverflow}, 32'h1);
        iRst = 1;
        cycle();
        iRst = 0;
        chk("t7_valid", {31'd0, oByte_valid}, 32'h0);
        chk("t7_err",   {31'd0, oFrame_err}, 32'h0);
        chk("t7_ovf",   {31'd0, oOverflow}, 32'h0);
        chk("t7_done",  {31'd0, oFrame_done}, 32'h0);
`ifdef XOR_RX_BITCOUNT_EN
        chk("t7_bitcnt", {22'd0, oBit_count}, 32'h0);
`endif

        // Randomised frames, gaps, stalls, aborts and resets
        for (int it = 0; it < 40; it++) begin
            int len;
            rdy_mode = $urandom_range(2);
            if ($urandom_range(3) == 0) load_key($urandom);
            rand_ct(ct);
            len = (it == 20) ? 530 : $urandom_range(1, 80);
            send_bits(ct, len, $urandom_range(5) != 0, $urandom_range(1) * 20);
            idle($urandom_range(0, 3));
            if ($urandom_range(9) == 0) begin
                iRst = 1;
                cycle();
                iRst = 0;
            end
        end
        rdy_mode = 1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
